// File: rtl/if_fetch.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four
// little-endian byte reads over an arbitrated port and holds it for decode.
module if_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        mem_grant,
   input  logic [7:0]  mem_din,
   output logic        if_mem_req,
   output logic [31:0] if_mem_addr,
   input  logic        id_stall,
   input  logic        jump_or_not,
   input  logic [31:0] jump_target,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        if_id_rdy,
   output logic        dbg_state
);

   // Memory handshake: a byte request is accepted when if_mem_req and
   // mem_grant are both high in a cycle; the byte arrives on mem_din exactly
   // one cycle later. Decode accepts inst_o/pc_o when if_id_rdy is high and
   // id_stall is low in the same cycle (with rdy high).

   typedef enum logic {FETCH = 1'b0, VALID = 1'b1} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] ibuf;
   logic [2:0]  issue_cnt;
   logic [2:0]  recv_cnt;
   logic        grant_d;
   logic        granted;

   assign if_mem_req  = rst && rdy && (state == FETCH) && (issue_cnt < 3'd4);
   assign if_mem_addr = pc + {29'd0, issue_cnt};
   assign granted     = mem_grant && if_mem_req;
   assign dbg_state   = (state == VALID);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         ibuf      <= 32'd0;
         issue_cnt <= 3'd0;
         recv_cnt  <= 3'd0;
         grant_d   <= 1'b0;
         pc_o      <= RESET_PC;
         inst_o    <= 32'd0;
         if_id_rdy <= 1'b0;
      end else if (!rdy) begin
         // Memory keeps running while we are frozen, so an in-flight byte
         // must still land; completion of the word is deferred to rdy.
         grant_d <= 1'b0;
         if (grant_d && (recv_cnt < 3'd4)) begin
            ibuf[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din;
            recv_cnt <= recv_cnt + 3'd1;
         end
      end else if (jump_or_not) begin
         state     <= FETCH;
         pc        <= jump_target;
         issue_cnt <= 3'd0;
         recv_cnt  <= 3'd0;
         grant_d   <= 1'b0;
         pc_o      <= jump_target;
         if_id_rdy <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               grant_d <= granted;
               if (granted) begin
                  issue_cnt <= issue_cnt + 3'd1;
               end
               if (grant_d) begin
                  ibuf[{recv_cnt[1:0], 3'b000} +: 8] <= mem_din;
                  recv_cnt <= recv_cnt + 3'd1;
                  if (recv_cnt == 3'd3) begin
                     inst_o    <= {mem_din, ibuf[23:0]};
                     pc_o      <= pc;
                     if_id_rdy <= 1'b1;
                     state     <= VALID;
                  end
               end else if (recv_cnt == 3'd4) begin
                  // Last byte was captured while frozen.
                  inst_o    <= ibuf;
                  pc_o      <= pc;
                  if_id_rdy <= 1'b1;
                  state     <= VALID;
               end
            end
            VALID: begin
               grant_d <= 1'b0;
               if (!id_stall) begin
                  pc        <= pc + 32'd4;
                  issue_cnt <= 3'd0;
                  recv_cnt  <= 3'd0;
                  if_id_rdy <= 1'b0;
                  state     <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a cycle table for the basic fetch/stall/consume
// flow plus hand-written sequences for grant gaps, jumps, rdy freeze and reset.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b0;
   logic        mem_grant = 1'b0;
   logic [7:0]  mem_din = 8'd0;
   logic        if_mem_req;
   logic [31:0] if_mem_addr;
   logic        id_stall = 1'b1;
   logic        jump_or_not = 1'b0;
   logic [31:0] jump_target = 32'hDEAD_BEEC;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        if_id_rdy;
   logic        dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .mem_grant   (mem_grant),
      .mem_din     (mem_din),
      .if_mem_req  (if_mem_req),
      .if_mem_addr (if_mem_addr),
      .id_stall    (id_stall),
      .jump_or_not (jump_or_not),
      .jump_target (jump_target),
      .pc_o        (pc_o),
      .inst_o      (inst_o),
      .if_id_rdy   (if_id_rdy),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   // Memory: 0x0-0x3 hold 13 05 10 00; elsewhere byte = addr[7:0] + 0x30.
   // Ungranted cycles return 0xEE so a spurious capture corrupts the word.
   function automatic logic [7:0] byte_at(input logic [31:0] a);
      case (a)
         32'h0:   byte_at = 8'h13;
         32'h1:   byte_at = 8'h05;
         32'h2:   byte_at = 8'h10;
         32'h3:   byte_at = 8'h00;
         default: byte_at = a[7:0] + 8'h30;
      endcase
   endfunction

   always @(posedge clk) begin
      mem_din <= (mem_grant && if_mem_req) ? byte_at(if_mem_addr) : 8'hEE;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input int max_cyc, output int n);
      n = 0;
      while (!if_id_rdy && n < max_cyc) begin
         cyc();
         n++;
         #1;
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        grant;
      logic        stall;
      logic        req;
      logic        chk_addr;
      logic [31:0] addr;
      logic        idr;
      logic [31:0] inst;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int n;
      int found;

      // rdy grant stall | req chk_addr addr idr inst pc
      vecs[0]  = '{1, 1, 1, 1, 1, 32'h0, 0, 32'h0, 32'h0};
      vecs[1]  = '{1, 1, 1, 1, 1, 32'h1, 0, 32'h0, 32'h0};
      vecs[2]  = '{1, 1, 1, 1, 1, 32'h2, 0, 32'h0, 32'h0};
      vecs[3]  = '{1, 1, 1, 1, 1, 32'h3, 0, 32'h0, 32'h0};
      vecs[4]  = '{1, 1, 1, 0, 0, 32'h0, 0, 32'h0, 32'h0};
      vecs[5]  = '{1, 1, 1, 0, 0, 32'h0, 1, 32'h0010_0513, 32'h0};
      vecs[6]  = '{1, 1, 1, 0, 0, 32'h0, 1, 32'h0010_0513, 32'h0};
      vecs[7]  = '{1, 1, 1, 0, 0, 32'h0, 1, 32'h0010_0513, 32'h0};
      vecs[8]  = '{1, 1, 0, 0, 0, 32'h0, 1, 32'h0010_0513, 32'h0};
      vecs[9]  = '{1, 1, 1, 1, 1, 32'h4, 0, 32'h0010_0513, 32'h0};
      vecs[10] = '{1, 1, 1, 1, 1, 32'h5, 0, 32'h0010_0513, 32'h0};
      vecs[11] = '{1, 1, 1, 1, 1, 32'h6, 0, 32'h0010_0513, 32'h0};
      vecs[12] = '{1, 1, 1, 1, 1, 32'h7, 0, 32'h0010_0513, 32'h0};
      vecs[13] = '{1, 1, 1, 0, 0, 32'h0, 0, 32'h0010_0513, 32'h0};
      vecs[14] = '{1, 1, 1, 0, 0, 32'h0, 1, 32'h3736_3534, 32'h4};

      // Reset state
      repeat (3) cyc();
      #1;
      chk("rst_req",   {31'd0, if_mem_req}, 32'd0);
      chk("rst_idr",   {31'd0, if_id_rdy},  32'd0);
      chk("rst_inst",  inst_o,              32'd0);
      chk("rst_pc",    pc_o,                32'd0);
      chk("rst_state", {31'd0, dbg_state},  32'd0);
      rst = 1'b1;

      // Full-grant fetch, 3-cycle stall, consume, second fetch
      for (int i = 0; i < 15; i++) begin
         cyc();
         rdy = vecs[i].rdy; mem_grant = vecs[i].grant; id_stall = vecs[i].stall;
         #1;
         chk($sformatf("v%0d_req", i), {31'd0, if_mem_req}, {31'd0, vecs[i].req});
         if (vecs[i].chk_addr) chk($sformatf("v%0d_addr", i), if_mem_addr, vecs[i].addr);
         chk($sformatf("v%0d_idr", i),  {31'd0, if_id_rdy}, {31'd0, vecs[i].idr});
         chk($sformatf("v%0d_inst", i), inst_o, vecs[i].inst);
         chk($sformatf("v%0d_pc", i),   pc_o,   vecs[i].pc);
      end
      chk("valid_state", {31'd0, dbg_state}, 32'd1);

      // Alternate grants (odd cycles): valid 4 cycles later than full grant
      cyc(); id_stall = 1'b0; mem_grant = 1'b0; #1;
      found = -1;
      for (int k = 0; k < 20; k++) begin
         cyc(); id_stall = 1'b1; mem_grant = (k % 2 == 1); #1;
         if (if_id_rdy) begin
            found = k;
            break;
         end
      end
      chk("alt_latency", found, 9);
      chk("alt_inst", inst_o, 32'h3B3A_3938);
      chk("alt_pc",   pc_o,   32'h8);

      // Jump while byte 2 is granted: byte discarded, refetch from 0x100
      mem_grant = 1'b1;
      cyc(); id_stall = 1'b0; #1;
      cyc(); id_stall = 1'b1; #1;
      chk("j1_addr0", if_mem_addr, 32'hC);
      cyc(); #1;
      cyc(); jump_or_not = 1'b1; jump_target = 32'h100; #1;
      chk("j1_addr2", if_mem_addr, 32'hE);
      cyc(); jump_or_not = 1'b0; jump_target = 32'hDEAD_BEEC; #1;
      chk("j1_addr",  if_mem_addr, 32'h100);
      chk("j1_pc_o",  pc_o,        32'h100);
      chk("j1_idr",   {31'd0, if_id_rdy}, 32'd0);
      wait_valid(12, n);
      chk("j1_valid", {31'd0, if_id_rdy}, 32'd1);
      chk("j1_lat",   n, 5);
      chk("j1_inst",  inst_o, 32'h3332_3130);
      chk("j1_pc",    pc_o,   32'h100);

      // Jump together with consume: target wins over pc+4
      cyc(); id_stall = 1'b0; jump_or_not = 1'b1; jump_target = 32'h240; #1;
      cyc(); id_stall = 1'b1; jump_or_not = 1'b0; jump_target = 32'hDEAD_BEEC; #1;
      chk("j2_addr", if_mem_addr, 32'h240);
      chk("j2_pc_o", pc_o,        32'h240);
      chk("j2_idr",  {31'd0, if_id_rdy}, 32'd0);
      wait_valid(12, n);
      chk("j2_valid", {31'd0, if_id_rdy}, 32'd1);
      chk("j2_inst",  inst_o, 32'h7372_7170);

      // rdy low for 2 cycles with one byte outstanding
      cyc(); id_stall = 1'b0; #1;
      cyc(); id_stall = 1'b1; #1;
      chk("f_addr0", if_mem_addr, 32'h244);
      cyc(); #1;
      chk("f_addr1", if_mem_addr, 32'h245);
      cyc(); rdy = 1'b0; #1;
      chk("f_req_a", {31'd0, if_mem_req}, 32'd0);
      cyc(); #1;
      chk("f_req_b", {31'd0, if_mem_req}, 32'd0);
      cyc(); rdy = 1'b1; #1;
      chk("f_addr2", if_mem_addr, 32'h246);
      wait_valid(12, n);
      chk("f_valid", {31'd0, if_id_rdy}, 32'd1);
      chk("f_inst",  inst_o, 32'h7776_7574);
      chk("f_pc",    pc_o,   32'h244);

      // Asynchronous reset mid-fetch
      cyc(); id_stall = 1'b0; #1;
      cyc(); id_stall = 1'b1; #1;
      chk("r_addr", if_mem_addr, 32'h248);
      #2; rst = 1'b0; #1;
      chk("r_idr",   {31'd0, if_id_rdy},  32'd0);
      chk("r_inst",  inst_o,              32'd0);
      chk("r_pc",    pc_o,                32'd0);
      chk("r_req",   {31'd0, if_mem_req}, 32'd0);
      chk("r_state", {31'd0, dbg_state},  32'd0);
      cyc(); cyc(); rst = 1'b1; #1;
      chk("r_req2",  {31'd0, if_mem_req}, 32'd1);
      chk("r_addr2", if_mem_addr,         32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage that produces the `pc` / `inst` / `if_id_rdy` triple consumed by the decode stage.
- Fetches each 32-bit instruction as four little-endian bytes over a byte-wide, arbitrated memory port.
- Holds the assembled instruction until decode accepts it (`id_stall` low).
- Redirects immediately on `jump_or_not`, discarding any in-flight byte.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous active-low reset (asserted when 0)
- rdy  input  1  global enable; 0 freezes all state and request issue
- mem_grant  input  1  arbiter accepted `if_mem_addr` this cycle
- mem_din  input  8  read byte; valid exactly one cycle after a grant
- if_mem_req  output  1  request a byte read
- if_mem_addr  output  32  byte address of the request
- id_stall  input  1  decode cannot accept; hold output
- jump_or_not  input  1  redirect fetch this cycle
- jump_target  input  32  redirect PC, valid with `jump_or_not`
- pc_o  output  32  PC of the instruction on `inst_o`
- inst_o  output  32  assembled instruction
- if_id_rdy  output  1  `inst_o` / `pc_o` valid for decode

Behaviour:
- Reset (async, `rst`=0):
  - `pc` = RESET_PC; issue_cnt = 0; recv_cnt = 0; grant_d = 0; state = FETCH.
  - Outputs: `if_id_rdy`=0, `inst_o`=0, `pc_o`=RESET_PC, `if_mem_req`=0.
  - After release, `if_mem_req` rises combinationally in the first cycle `rdy`=1.
- State FETCH:
  - `if_mem_req` = rdy && (issue_cnt < 4); `if_mem_addr` = pc + issue_cnt (32-bit wrap).
  - On `mem_grant` && `if_mem_req`: issue_cnt++ and grant_d <= 1, else grant_d <= 0.
  - When grant_d=1: byte buf[8*recv_cnt +: 8] <= `mem_din`; recv_cnt++.
  - When the 4th byte is captured: `inst_o` <= assembled word, `pc_o` <= pc, `if_id_rdy` <= 1, state -> VALID.
- State VALID:
  - `if_id_rdy`=1; `if_mem_req`=0.
  - If rdy && !`id_stall`: pc <= pc + 4, counters cleared, `if_id_rdy` <= 0, state -> FETCH.
  - Otherwise hold every output unchanged.
- Latency with grant every cycle: request cycles 0–3, bytes captured cycles 1–4, `if_id_rdy`=1 from cycle 5. Best-case throughput is one instruction per 6 cycles. Grant gaps add cycles one-for-one.
- Byte order: byte at pc+k lands in `inst_o`[8k+7:8k].
- Jump (rdy=1, `jump_or_not`=1), highest priority over consume, capture and issue in any state:
  - Next cycle: pc <= `jump_target`; issue_cnt = recv_cnt = 0; grant_d <= 0; `if_id_rdy` <= 0; state -> FETCH.
  - A grant in the jump cycle is consumed by the arbiter, but its returning byte is discarded (grant_d cleared).
  - `pc_o` <= `jump_target`.
- rdy=0:
  - No state change, `if_mem_req`=0, outputs held.
  - Exception: a byte returning from a grant in the previous cycle is still captured (memory is not frozen).
- Misaligned `jump_target` is fetched as-is; no alignment check.
- `mem_grant` while `if_mem_req`=0 is ignored.

Test Plan:
- Reset then `rst`=1, `rdy`=1, grant every cycle, memory bytes 0x13,0x05,0x10,0x00 at 0x0–0x3 -> `if_mem_addr` 0,1,2,3 on cycles 0–3; cycle 5 `if_id_rdy`=1, `inst_o`=32'h00100513, `pc_o`=0.
- Hold `id_stall`=1 for 3 cycles in VALID -> `if_id_rdy`, `inst_o`, `pc_o` constant and `if_mem_req`=0. Drop `id_stall` -> next cycle `if_mem_addr`=0x4, `if_id_rdy`=0.
- Grant only on alternate cycles -> `if_id_rdy` rises 4 cycles later than the full-grant case with an identical `inst_o`; no byte duplicated or skipped.
- Assert `jump_or_not`, `jump_target`=0x100 in the cycle byte 2 is granted -> returned byte ignored; next cycle `if_mem_addr`=0x100, `pc_o`=0x100; next `inst_o` is built solely from 0x100–0x103.
- `jump_or_not` together with consume in VALID (`id_stall`=0) -> pc = `jump_target`, not pc+4.
- Deassert `rdy` for 2 cycles mid-FETCH, with one byte outstanding -> outstanding byte captured, no new requests, counters frozen. Resume -> correct word. Pulling `rst` low mid-fetch -> outputs return to reset values immediately (asynchronous).
